// File: rtl/fifo_pkg.sv
// Shared types and defaults for the FIFO read-side packer.
// word_t describes one packed output word at the default geometry.
package fifo_pkg;

    localparam int DATASIZE_DEF = 8;
    localparam int PACK_DEF     = 4;

    typedef enum logic {
        ACC,
        FLUSH
    } pack_state_t;

    typedef struct packed {
        logic [DATASIZE_DEF*PACK_DEF-1:0] data;
        logic [PACK_DEF-1:0]              keep;
        logic                             last;
    } word_t;

endpackage

// File: rtl/pack_skid_buf.sv
// Two-entry output buffer for packed words with a valid/ready master side.
// The head entry drives the outputs directly from a register.
module pack_skid_buf
    import fifo_pkg::*;
#(
    parameter type T = word_t
) (
    input  logic clk,
    input  logic rst_n,
    input  logic push,
    input  T     push_word,
    output logic full,
    output logic m_valid,
    input  logic m_ready,
    output T     m_word
);

    logic [1:0] cnt_reg;
    T           head_reg;
    T           tail_reg;
    logic       pop;

    assign pop     = m_valid && m_ready;
    assign full    = (cnt_reg == 2'd2);
    assign m_valid = (cnt_reg != 2'd0);
    assign m_word  = head_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg  <= 2'd0;
            head_reg <= '0;
            tail_reg <= '0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (cnt_reg == 2'd0) head_reg <= push_word;
                    else                 tail_reg <= push_word;
                    cnt_reg <= cnt_reg + 2'd1;
                end
                2'b01: begin
                    head_reg <= tail_reg;
                    cnt_reg  <= cnt_reg - 2'd1;
                end
                2'b11: begin
                    // occupancy is unchanged; the new word lands behind whatever remains
                    if (cnt_reg == 2'd1) begin
                        head_reg <= push_word;
                    end else begin
                        head_reg <= tail_reg;
                        tail_reg <= push_word;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/fifo_rd_packer.sv
// Pops FIFO entries and packs PACK of them little-endian into one wide word;
// a flush closes the current partial word with a keep mask and last flag.
module fifo_rd_packer
    import fifo_pkg::*;
#(
    parameter int DATASIZE = DATASIZE_DEF,
    parameter int PACK     = PACK_DEF
) (
    input  logic                     rclk,
    input  logic                     rrst_n,
    input  logic                     rempty,
    input  logic [DATASIZE-1:0]      rdata,
    output logic                     rinc,
    input  logic                     flush,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic [DATASIZE*PACK-1:0] m_data,
    output logic [PACK-1:0]          m_keep,
    output logic                     m_last
);

    localparam int              CW        = $clog2(PACK);
    localparam int              WW        = DATASIZE * PACK;
    localparam logic [CW-1:0]   LAST_LANE = CW'(PACK - 1);

    typedef struct packed {
        logic [WW-1:0]   data;
        logic [PACK-1:0] keep;
        logic            last;
    } pword_t;

    pack_state_t     state_reg, state_next;
    logic [CW-1:0]   cnt_reg, cnt_next;
    logic [WW-1:0]   acc_reg, acc_next, acc_wr;
    logic            active_reg;
    logic            flush_pend;
    logic            push;
    logic            full;
    logic [PACK-1:0] part_keep;
    pword_t          push_word;
    pword_t          out_word;

    // active_reg keeps rinc low while in reset and for the first edge after release
    assign flush_pend = (state_reg == FLUSH);
    assign rinc = active_reg && !rempty && !flush_pend && ((cnt_reg != LAST_LANE) || !full);

    generate
        for (genvar gi = 0; gi < PACK; gi++) begin : g_keep
            assign part_keep[gi] = (CW'(gi) < cnt_reg);
        end
    endgenerate

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        acc_next   = acc_reg;
        push       = 1'b0;
        push_word  = '0;
        acc_wr     = acc_reg;
        if (rinc) acc_wr[cnt_reg*DATASIZE +: DATASIZE] = rdata;

        case (state_reg)
            ACC: begin
                if (rinc && (cnt_reg == LAST_LANE)) begin
                    // a flush coinciding with the completing pop just tags the full word
                    push           = 1'b1;
                    push_word.data = acc_wr;
                    push_word.keep = '1;
                    push_word.last = flush;
                    acc_next       = '0;
                    cnt_next       = '0;
                end else begin
                    if (rinc) begin
                        acc_next = acc_wr;
                        cnt_next = cnt_reg + CW'(1);
                    end
                    if (flush && (rinc || (cnt_reg != '0))) state_next = FLUSH;
                end
            end
            FLUSH: begin
                if (!full) begin
                    push           = 1'b1;
                    push_word.data = acc_reg;
                    push_word.keep = part_keep;
                    push_word.last = 1'b1;
                    acc_next       = '0;
                    cnt_next       = '0;
                    state_next     = ACC;
                end
            end
            default: state_next = ACC;
        endcase
    end

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            state_reg  <= ACC;
            cnt_reg    <= '0;
            acc_reg    <= '0;
            active_reg <= 1'b0;
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            acc_reg    <= acc_next;
            active_reg <= 1'b1;
        end
    end

    pack_skid_buf #(
        .T (pword_t)
    ) u_buf (
        .clk       (rclk),
        .rst_n     (rrst_n),
        .push      (push),
        .push_word (push_word),
        .full      (full),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_word    (out_word)
    );

    assign m_data = out_word.data;
    assign m_keep = out_word.keep;
    assign m_last = out_word.last;

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Directed bench for fifo_rd_packer with a simple array-backed FIFO model
// and a negedge monitor that logs pops and accepted output words.
module tb_fifo_rd_packer;

    logic        clk = 1'b0;
    logic        rrst_n;
    logic        rempty;
    logic [7:0]  rdata;
    logic        rinc;
    logic        flush;
    logic        m_valid;
    logic        m_ready;
    logic [31:0] m_data;
    logic [3:0]  m_keep;
    logic        m_last;

    logic [7:0]  fmem [0:63];
    int          rd_ptr = 0;
    int          wr_ptr = 0;
    logic        hold_empty;

    int          ncyc = 0;
    int          pops_total = 0;
    int          valid_total = 0;
    int          viol_total = 0;
    logic [36:0] out_q [$];
    int          popcyc_q [$];
    int          hscyc_q [$];

    int          tests = 0;
    int          fails = 0;

    always #5 clk = ~clk;

    assign rempty = hold_empty || (rd_ptr == wr_ptr);
    assign rdata  = fmem[rd_ptr[5:0]];

    always @(posedge clk) begin
        if (rinc) rd_ptr <= rd_ptr + 1;
    end

    always @(negedge clk) begin
        ncyc <= ncyc + 1;
        if (rinc) begin
            pops_total <= pops_total + 1;
            popcyc_q.push_back(ncyc);
        end
        if (rinc && rempty) viol_total <= viol_total + 1;
        if (m_valid) valid_total <= valid_total + 1;
        if (m_valid && m_ready) begin
            out_q.push_back({m_data, m_keep, m_last});
            hscyc_q.push_back(ncyc);
        end
    end

    fifo_rd_packer dut (
        .rclk    (clk),
        .rrst_n  (rrst_n),
        .rempty  (rempty),
        .rdata   (rdata),
        .rinc    (rinc),
        .flush   (flush),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_data  (m_data),
        .m_keep  (m_keep),
        .m_last  (m_last)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [36:0] get_word(input int idx);
        if (idx < out_q.size()) return out_q[idx];
        return 'x;
    endfunction

    function automatic int get_int(input int q [$], input int idx);
        if (idx < q.size()) return q[idx];
        return -1000;
    endfunction

    task automatic push_fifo(input logic [7:0] v);
        fmem[wr_ptr[5:0]] = v;
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        rrst_n     = 1'b0;
        flush      = 1'b0;
        m_ready    = 1'b0;
        hold_empty = 1'b0;

        // reset state, FIFO already holding the first word
        push_fifo(8'h11); push_fifo(8'h22); push_fifo(8'h33); push_fifo(8'h44);
        tick(2);
        check("rst_m_valid", 64'(m_valid), 64'd0);
        check("rst_m_data",  64'(m_data),  64'd0);
        check("rst_m_keep",  64'(m_keep),  64'd0);
        check("rst_m_last",  64'(m_last),  64'd0);
        check("rst_rinc",    64'(rinc),    64'd0);

        // first word, m_ready high
        m_ready = 1'b1;
        rrst_n  = 1'b1;
        tick(10);
        check("w1_pops", 64'(pops_total), 64'd4);
        check("w1_consecutive", 64'(get_int(popcyc_q, 3) - get_int(popcyc_q, 0)), 64'd3);
        check("w1_word", 64'(get_word(0)), 64'({32'h44332211, 4'hF, 1'b0}));
        check("w1_valid_cycles", 64'(valid_total), 64'd1);
        check("w1_latency", 64'(get_int(hscyc_q, 0) - get_int(popcyc_q, 3)), 64'd1);

        // backpressure: two words buffered, third word stalls at its last lane
        m_ready = 1'b0;
        for (int i = 1; i <= 12; i++) push_fifo(8'(i));
        tick(16);
        check("bp_pops", 64'(pops_total), 64'd15);
        check("bp_rinc_held", 64'(rinc), 64'd0);
        check("bp_rempty", 64'(rempty), 64'd0);
        check("bp_m_valid", 64'(m_valid), 64'd1);
        check("bp_head", 64'({m_data, m_keep}), 64'({32'h04030201, 4'hF}));
        tick(3);
        check("bp_stable", 64'({m_data, m_keep, m_last}), 64'({32'h04030201, 4'hF, 1'b0}));
        m_ready = 1'b1;
        tick(10);
        check("bp_count", 64'(out_q.size()), 64'd4);
        check("bp_word1", 64'(get_word(1)), 64'({32'h04030201, 4'hF, 1'b0}));
        check("bp_word2", 64'(get_word(2)), 64'({32'h08070605, 4'hF, 1'b0}));
        check("bp_word3", 64'(get_word(3)), 64'({32'h0C0B0A09, 4'hF, 1'b0}));
        check("bp_resume_pops", 64'(pops_total), 64'd16);

        // partial flush after two entries
        push_fifo(8'hAA); push_fifo(8'hBB);
        tick(4);
        flush = 1'b1;
        tick(1);
        flush = 1'b0;
        push_fifo(8'hCC);
        check("fl_rinc_in_flush", 64'(rinc), 64'd0);
        tick(6);
        check("fl_count", 64'(out_q.size()), 64'd5);
        check("fl_word", 64'(get_word(4)), 64'({32'h0000BBAA, 4'h3, 1'b1}));
        flush = 1'b1;
        tick(1);
        flush = 1'b0;
        tick(5);
        check("fl_word_single", 64'(get_word(5)), 64'({32'h000000CC, 4'h1, 1'b1}));

        // flush coinciding with the completing pop
        push_fifo(8'h01); push_fifo(8'h02); push_fifo(8'h03); push_fifo(8'h04);
        tick(3);
        flush = 1'b1;
        check("fc_rinc_4th", 64'(rinc), 64'd1);
        tick(1);
        flush = 1'b0;
        tick(6);
        check("fc_count", 64'(out_q.size()), 64'd7);
        check("fc_word", 64'(get_word(6)), 64'({32'h04030201, 4'hF, 1'b1}));

        // flush with nothing accumulated, then rempty toggling
        flush = 1'b1;
        tick(1);
        flush = 1'b0;
        tick(5);
        check("fz_no_word", 64'(out_q.size()), 64'd7);
        hold_empty = 1'b1;
        push_fifo(8'hE1); push_fifo(8'hE2); push_fifo(8'hE3); push_fifo(8'hE4);
        for (int i = 0; i < 12; i++) begin
            tick(1);
            hold_empty = !hold_empty;
        end
        hold_empty = 1'b0;
        tick(5);
        check("te_no_illegal_rinc", 64'(viol_total), 64'd0);
        check("te_count", 64'(out_q.size()), 64'd8);
        check("te_word", 64'(get_word(7)), 64'({32'hE4E3E2E1, 4'hF, 1'b0}));

        // reset with a buffered word and a partial accumulator
        m_ready = 1'b0;
        for (int i = 0; i < 6; i++) push_fifo(8'(8'h31 + i));
        tick(10);
        check("mr_pre_valid", 64'(m_valid), 64'd1);
        #2;
        rrst_n = 1'b0;
        #1;
        check("mr_m_valid", 64'(m_valid), 64'd0);
        check("mr_m_data",  64'(m_data),  64'd0);
        check("mr_m_keep",  64'(m_keep),  64'd0);
        check("mr_m_last",  64'(m_last),  64'd0);
        check("mr_rinc",    64'(rinc),    64'd0);
        @(posedge clk);
        #1;
        rrst_n  = 1'b1;
        m_ready = 1'b1;
        push_fifo(8'h41); push_fifo(8'h42); push_fifo(8'h43); push_fifo(8'h44);
        tick(10);
        check("mr_count", 64'(out_q.size()), 64'd9);
        check("mr_clean_word", 64'(get_word(8)), 64'({32'h44434241, 4'hF, 1'b0}));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
